// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } grant_t;

   function automatic grant_t other_port(input grant_t g);
      return (g == GNT_IF) ? GNT_D : GNT_IF;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; on a collision the port not granted last wins.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic   req_if_i,
   input  logic   req_d_i,
   input  grant_t last_grant_i,
   output grant_t grant_c_o,
   output logic   valid_c_o
);

   always_comb begin
      valid_c_o = req_if_i | req_d_i;
      grant_c_o = GNT_IF;
      if (req_if_i && req_d_i) begin
         grant_c_o = other_port(last_grant_i);
      end else if (req_d_i) begin
         grant_c_o = GNT_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and data ports,
// one transaction at a time: IDLE -> ISSUE -> WAIT -> RESP.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   output logic          if_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          d_stall,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned CW = $clog2(LAT + 1);

   state_t        state_q,     state_d;
   grant_t        last_q,      last_d;
   grant_t        gnt_q,       gnt_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          mem_en_q,    mem_en_d;
   logic          mem_we_q,    mem_we_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] if_rdata_q,  if_rdata_d;
   logic [DW-1:0] d_rdata_q,   d_rdata_d;
   logic          if_ready_q,  if_ready_d;
   logic          d_ready_q,   d_ready_d;

   grant_t        arb_gnt;
   logic          arb_valid;

   rr_arbiter2 u_rr (
      .req_if_i     (if_req),
      .req_d_i      (d_req),
      .last_grant_i (last_q),
      .grant_c_o    (arb_gnt),
      .valid_c_o    (arb_valid)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_ready_d  = 1'b0;
      d_ready_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt_d    = arb_gnt;
               last_d   = arb_gnt;
               mem_en_d = 1'b1;
               state_d  = ISSUE;
               if (arb_gnt == GNT_D) begin
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end else begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
               end
            end
         end
         ISSUE: begin
            cnt_d   = CW'(LAT);
            state_d = WAIT;
         end
         // Capture lands in the last WAIT cycle, when mem_rdata is valid.
         WAIT: begin
            if (cnt_q == CW'(1)) begin
               cnt_d   = '0;
               state_d = RESP;
               if (gnt_q == GNT_D) begin
                  d_rdata_d = mem_rdata;
                  d_ready_d = 1'b1;
               end else begin
                  if_rdata_d = mem_rdata;
                  if_ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= GNT_IF;
         gnt_q       <= GNT_IF;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_ready_q  <= if_ready_d;
         d_ready_q   <= d_ready_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_ready  = if_ready_q;
   assign d_ready   = d_ready_q;

   // Stall terms stay combinational so the hazard unit sees them in the request cycle.
   assign if_stall = if_req & ~if_ready_q;
   assign d_stall  = d_req & ~d_ready_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port and data-memory port. It accepts held requests from both ports and issues one memory command at a time. It returns read data with a one-cycle ready pulse and exposes stall terms for the hazard unit. It sits between the datapath (pcF/instrF, aluoutM/writedataM/readdataM) and the unified memory.

## Interface
Parameters:
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width
- LAT, 2, memory read latency in cycles; must be ≥1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  AW  fetch address (pcF)
- if_rdata  out  DW  fetched instruction; valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_ready (combinational)
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address (aluoutM)
- d_wdata  in  DW  store data (writedataM)
- d_rdata  out  DW  load data; valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- d_stall  out  1  d_req & ~d_ready (combinational)
- mem_en  out  1  memory command strobe, one cycle per transaction
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, no request: stay.
- IDLE, one request pending: grant it, latch addr, we and wdata, then go to ISSUE.
- IDLE, both pending: round-robin on last_grant. The port not granted last wins. last_grant resets to IF, so the first collision goes to data.
- ISSUE: mem_en=1 with latched mem_we, mem_addr and mem_wdata. Load the counter with LAT, then go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, capture mem_rdata into the granted port's rdata register and go to RESP.
- RESP: assert the granted port's ready for exactly one cycle. Requests are ignored in RESP. Go to IDLE.
- Stores use the same timing. The write commits in the ISSUE cycle, the captured rdata is don't-care, and d_ready still pulses.
- Only the granted port's ready may pulse. The other port's rdata register holds its last value.
- Requester rule: keep req and its payload stable until ready is seen. Req may drop or change in the cycle after ready.
- Counter width: $clog2(LAT+1). With LAT=1, WAIT lasts exactly one cycle.
- Reset at any point:
  - state=IDLE, last_grant=IF.
  - mem_en, mem_we, if_ready and d_ready are 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata are 0.
  - The counter is 0, and any in-flight transaction is dropped with its response ignored.
- All outputs except the stall terms are registered.

## Timing
- Request seen in IDLE at cycle 0 (single port):
  - mem_en in cycle 1.
  - mem_rdata sampled at the end of cycle 1+LAT.
  - ready in cycle 2+LAT (cycle 4 for LAT=2).
- Back-to-back on the same port: the earliest next grant is in the IDLE cycle after RESP. Throughput is one transaction per LAT+3 cycles.
- Collision: the loser's request stays pending. It is granted in the IDLE cycle following the winner's RESP, so its ready arrives at 2·(LAT+3)−1 cycles after cycle 0.
- if_stall and d_stall are high in every cycle the port's req=1 and ready=0, including cycles 0 through 1+LAT.

## Structure
- Package mem_arb_pkg holds:
  - state_t enum (IDLE, ISSUE, WAIT, RESP);
  - grant_t enum (GNT_IF, GNT_D).
- Sub-module rr_arbiter2 is the two-requester round-robin picker. It is combinational on req and the last_grant input, and outputs grant_t plus a valid bit. The FSM owns the last_grant register.

## Test plan
- Single fetch, LAT=2: if_req=1 with if_addr=0x40 at cycle 0, memory returns 0x2002_0005. Expect mem_en only in cycle 1 with mem_addr=0x40 and mem_we=0. Expect if_ready only in cycle 4 with if_rdata=0x2002_0005, if_stall high in cycles 0–3, and d_ready never asserted.
- Store: d_req=1, d_we=1, d_addr=0x80, d_wdata=0xDEAD_BEEF. Expect mem_en, mem_we, mem_addr=0x80 and mem_wdata=0xDEAD_BEEF in cycle 1, and d_ready in cycle 4.
- Collision from reset: both requests at cycle 0. Expect data granted first with d_ready in cycle 4. Expect fetch mem_en in cycle 6 and if_ready in cycle 9.
- Repeated collisions: both requests held and re-issued after each ready. Expect grants strictly alternating D, IF, D, IF with no port served twice in a row.
- Reset mid-WAIT: assert reset in cycle 2 of a load. Expect all outputs 0 from the next cycle and no ready pulse. A fresh fetch issued afterwards completes at the standard offset of 2+LAT.
- LAT=1 instance: single load. Expect mem_en in cycle 1 and d_ready in cycle 3.
